// File: rtl/ram_axi_bridge_pkg.sv
// Shared definitions for the RAM-to-AXI4 single-beat bridge:
// AXI burst and response encodings, the ID width and the FSM state type.
package ram_axi_bridge_pkg;

    localparam int AXI_ID_W = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/ram_axi_bridge_if.sv
// AXI4 bus bundle between the bridge (master) and the memory system (slave).
interface ram_axi_bridge_if;
    import ram_axi_bridge_pkg::*;

    logic                aw_valid;
    logic                aw_ready;
    logic [63:0]         aw_addr;
    logic [AXI_ID_W-1:0] aw_id;
    logic [7:0]          aw_len;
    logic [2:0]          aw_size;
    logic [1:0]          aw_burst;

    logic                w_valid;
    logic                w_ready;
    logic [63:0]         w_data;
    logic [7:0]          w_strb;
    logic                w_last;

    logic                b_valid;
    logic                b_ready;
    logic [1:0]          b_resp;
    logic [AXI_ID_W-1:0] b_id;

    logic                ar_valid;
    logic                ar_ready;
    logic [63:0]         ar_addr;
    logic [AXI_ID_W-1:0] ar_id;
    logic [7:0]          ar_len;
    logic [2:0]          ar_size;
    logic [1:0]          ar_burst;

    logic                r_valid;
    logic                r_ready;
    logic [63:0]         r_data;
    logic [1:0]          r_resp;
    logic                r_last;
    logic [AXI_ID_W-1:0] r_id;

    modport master (
        output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_resp, b_id,
        output b_ready,
        output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
        input  ar_ready,
        input  r_valid, r_data, r_resp, r_last, r_id,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_resp, b_id,
        input  b_ready,
        input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
        output ar_ready,
        output r_valid, r_data, r_resp, r_last, r_id,
        input  r_ready
    );

endinterface

// File: rtl/ram_axi_bridge.sv
// RAM-style request port to AXI4 master bridge, one single-beat transaction
// outstanding at a time. Request fields are latched on acceptance and every
// AXI payload is driven from that copy.
// Optional feature: define RAM_AXI_BRIDGE_RESP_CHECK_EN to flag non-OKAY
// read/write responses on the sticky bus_err_o output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for cen; latches the request when it arrives
// RD_ADDR | ar_valid held until the read address is accepted
// RD_DATA | r_ready high, waiting for the read beat
// WR_REQ  | aw_valid / w_valid, each dropped after its own handshake
// WR_RESP | b_ready high, waiting for the write response
// DONE    | one-cycle ram_rw_ready_o pulse, then back to IDLE
module ram_axi_bridge
    import ram_axi_bridge_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    ram_rw_cen_i,
    input  logic                    ram_rw_wen_i,
    input  logic [63:0]             ram_rw_addr_i,
    input  logic [63:0]             ram_rw_wdata_i,
    input  logic [7:0]              ram_rw_wmask_i,
    input  logic [2:0]              ram_rw_size_i,
    output logic                    ram_rw_ready_o,
    output logic [63:0]             ram_rw_data_o,

    output logic                    bus_err_o,

    ram_axi_bridge_if.master        axi
);

    state_t      r_state;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_wmask;
    logic [2:0]  r_size;
    logic        r_wen;

    logic        r_ar_valid;
    logic        r_r_ready;
    logic        r_aw_valid;
    logic        r_w_valid;
    logic        r_b_ready;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_rw_ready;
    logic [63:0] r_rdata;

    wire w_ar_hs = r_ar_valid & axi.ar_ready;
    wire w_r_hs  = r_r_ready  & axi.r_valid;
    wire w_aw_hs = r_aw_valid & axi.aw_ready;
    wire w_w_hs  = r_w_valid  & axi.w_ready;
    wire w_b_hs  = r_b_ready  & axi.b_valid;

    // Done-so-far including this cycle, so a same-cycle AW+W finish advances.
    wire w_aw_done_nxt = r_aw_done | w_aw_hs;
    wire w_w_done_nxt  = r_w_done  | w_w_hs;

    assign axi.aw_valid = r_aw_valid;
    assign axi.aw_addr  = r_addr;
    assign axi.aw_id    = AXI_ID_W'(0);
    assign axi.aw_len   = 8'd0;
    assign axi.aw_size  = r_size;
    assign axi.aw_burst = BURST_INCR;

    assign axi.w_valid  = r_w_valid;
    assign axi.w_data   = r_wdata;
    assign axi.w_strb   = r_wmask;
    assign axi.w_last   = 1'b1;

    assign axi.b_ready  = r_b_ready;

    assign axi.ar_valid = r_ar_valid;
    assign axi.ar_addr  = r_addr;
    assign axi.ar_id    = AXI_ID_W'(0);
    assign axi.ar_len   = 8'd0;
    assign axi.ar_size  = r_size;
    assign axi.ar_burst = BURST_INCR;

    assign axi.r_ready  = r_r_ready;

    assign ram_rw_ready_o = r_rw_ready;
    assign ram_rw_data_o  = r_rdata;

    // Transaction FSM with registered handshake outputs and latched request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_size     <= '0;
            r_wen      <= 1'b0;
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b0;
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_b_ready  <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_rw_ready <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ram_rw_cen_i) begin
                        r_addr  <= ram_rw_addr_i;
                        r_wdata <= ram_rw_wdata_i;
                        r_wmask <= ram_rw_wmask_i;
                        r_size  <= ram_rw_size_i;
                        r_wen   <= ram_rw_wen_i;
                        if (ram_rw_wen_i) begin
                            r_aw_valid <= 1'b1;
                            r_w_valid  <= 1'b1;
                            r_state    <= WR_REQ;
                        end else begin
                            r_ar_valid <= 1'b1;
                            r_state    <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (w_ar_hs) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_state    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (w_r_hs) begin
                        r_r_ready  <= 1'b0;
                        r_rdata    <= axi.r_data;
                        r_rw_ready <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                WR_REQ: begin
                    if (w_aw_hs) r_aw_valid <= 1'b0;
                    if (w_w_hs)  r_w_valid  <= 1'b0;
                    if (w_aw_done_nxt && w_w_done_nxt) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_b_ready <= 1'b1;
                        r_state   <= WR_RESP;
                    end else begin
                        r_aw_done <= w_aw_done_nxt;
                        r_w_done  <= w_w_done_nxt;
                    end
                end
                WR_RESP: begin
                    if (w_b_hs) begin
                        r_b_ready  <= 1'b0;
                        r_rw_ready <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    r_rw_ready <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef RAM_AXI_BRIDGE_RESP_CHECK_EN
    logic r_bus_err;
    wire  w_resp_err = (w_r_hs && (axi.r_resp != RESP_OKAY)) ||
                       (w_b_hs && (axi.b_resp != RESP_OKAY));

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n)          r_bus_err <= 1'b0;
        else if (w_resp_err) r_bus_err <= 1'b1;
    end

    assign bus_err_o = r_bus_err;

    // IDs/last are fixed for single-beat ID-0 traffic; wen kept for debug visibility.
    wire w_unused = ^{axi.b_id, axi.r_id, axi.r_last, r_wen};
`else
    assign bus_err_o = 1'b0;

    // IDs/last are fixed for single-beat ID-0 traffic; responses are not checked.
    wire w_unused = ^{axi.b_id, axi.r_id, axi.r_last, axi.r_resp, axi.b_resp, r_wen};
`endif

endmodule

// File: tb/tb_ram_axi_bridge.sv
// Directed bench for ram_axi_bridge: the bench plays the AXI slave
// cycle by cycle (driving on the falling edge) and checks handshakes,
// latched payload, latency, back-to-back flow, error flag and reset abort.
module tb_ram_axi_bridge;
    import ram_axi_bridge_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ram_rw_cen_i;
    logic        ram_rw_wen_i;
    logic [63:0] ram_rw_addr_i;
    logic [63:0] ram_rw_wdata_i;
    logic [7:0]  ram_rw_wmask_i;
    logic [2:0]  ram_rw_size_i;
    logic        ram_rw_ready_o;
    logic [63:0] ram_rw_data_o;
    logic        bus_err_o;

    ram_axi_bridge_if axi ();

    ram_axi_bridge dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ram_rw_cen_i   (ram_rw_cen_i),
        .ram_rw_wen_i   (ram_rw_wen_i),
        .ram_rw_addr_i  (ram_rw_addr_i),
        .ram_rw_wdata_i (ram_rw_wdata_i),
        .ram_rw_wmask_i (ram_rw_wmask_i),
        .ram_rw_size_i  (ram_rw_size_i),
        .ram_rw_ready_o (ram_rw_ready_o),
        .ram_rw_data_o  (ram_rw_data_o),
        .bus_err_o      (bus_err_o),
        .axi            (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-transaction observations.
    int          ar_cyc, aw_cyc, w_cyc, rdy_cnt, lat, first_v, extra_v;
    logic [63:0] ar_addr_s, aw_addr_s, w_data_s;
    logic [7:0]  ar_len_s, aw_len_s, w_strb_s;
    logic [2:0]  ar_size_s;
    logic [1:0]  ar_burst_s, aw_burst_s;
    logic [3:0]  ar_id_s, aw_id_s;
    logic        w_last_s;
    logic        exp_err;
    bit          got_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        axi.ar_ready = 1'b0;
        axi.aw_ready = 1'b0;
        axi.w_ready  = 1'b0;
        axi.r_valid  = 1'b0;
        axi.b_valid  = 1'b0;
    endtask

    // Issue one request and act as the AXI slave until the ready pulse
    // (or, with abort, until b_ready appears). The cen cycle is cycle 1.
    task automatic run_txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] wmask, input logic [2:0] size, input int aw_dly,
                           input logic [63:0] rdata, input logic [1:0] resp,
                           input bit hold, input bit scramble, input bit abort);
        ar_cyc = 0; aw_cyc = 0; w_cyc = 0; rdy_cnt = 0; lat = 0; first_v = 0; extra_v = 0;
        got_done = 0;
        ram_rw_cen_i   = 1'b1;
        ram_rw_wen_i   = wen;
        ram_rw_addr_i  = addr;
        ram_rw_wdata_i = wdata;
        ram_rw_wmask_i = wmask;
        ram_rw_size_i  = size;
        for (int n = 2; n <= 60; n++) begin
            @(negedge clk);
            if (axi.ar_valid) begin
                ar_cyc++;
                ar_addr_s = axi.ar_addr; ar_len_s = axi.ar_len; ar_size_s = axi.ar_size;
                ar_burst_s = axi.ar_burst; ar_id_s = axi.ar_id;
            end
            if (axi.aw_valid) begin
                aw_cyc++;
                aw_addr_s = axi.aw_addr; aw_len_s = axi.aw_len;
                aw_burst_s = axi.aw_burst; aw_id_s = axi.aw_id;
            end
            if (axi.w_valid) begin
                w_cyc++;
                w_data_s = axi.w_data; w_strb_s = axi.w_strb; w_last_s = axi.w_last;
            end
            if ((axi.ar_valid || axi.aw_valid) && first_v == 0) first_v = n;
            if (ram_rw_ready_o) begin
                rdy_cnt++;
                lat = n;
                got_done = 1;
            end
            if (abort && axi.b_ready) got_done = 1;
            axi.ar_ready = axi.ar_valid;
            axi.aw_ready = axi.aw_valid && (aw_cyc >= aw_dly);
            axi.w_ready  = axi.w_valid;
            axi.r_valid  = axi.r_ready;
            axi.r_data   = rdata;
            axi.r_resp   = resp;
            axi.b_valid  = axi.b_ready && !abort;
            axi.b_resp   = resp;
            if (!hold && (ar_cyc + aw_cyc) > 0) ram_rw_cen_i = 1'b0;
            if (scramble && axi.r_ready) begin
                ram_rw_addr_i  = 64'hFFFF_0000_DEAD_0000;
                ram_rw_wen_i   = 1'b1;
                ram_rw_wdata_i = 64'h0BAD_0BAD_0BAD_0BAD;
                ram_rw_size_i  = 3'd0;
            end
            if (got_done) break;
        end
        chk("txn_completed_in_budget", 64'(got_done), 64'd1);
        slave_idle();
        if (!hold && !abort) begin
            repeat (2) begin
                @(negedge clk);
                if (ram_rw_ready_o) rdy_cnt++;
                if (axi.ar_valid || axi.aw_valid || axi.w_valid) extra_v++;
            end
        end
    endtask

    initial begin
`ifdef RAM_AXI_BRIDGE_RESP_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst_n = 1'b0;
        ram_rw_cen_i = 1'b0; ram_rw_wen_i = 1'b0; ram_rw_addr_i = '0;
        ram_rw_wdata_i = '0; ram_rw_wmask_i = '0; ram_rw_size_i = '0;
        axi.r_data = '0; axi.r_resp = 2'b00; axi.r_last = 1'b1; axi.r_id = '0;
        axi.b_resp = 2'b00; axi.b_id = '0;
        slave_idle();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready",    64'(ram_rw_ready_o), 64'd0);
        chk("rst_data",     ram_rw_data_o,       64'd0);
        chk("rst_bus_err",  64'(bus_err_o),      64'd0);
        chk("rst_ar_valid", 64'(axi.ar_valid),   64'd0);
        chk("rst_aw_valid", 64'(axi.aw_valid),   64'd0);
        chk("rst_w_valid",  64'(axi.w_valid),    64'd0);
        chk("rst_r_ready",  64'(axi.r_ready),    64'd0);
        chk("rst_b_ready",  64'(axi.b_ready),    64'd0);
        chk("rst_ar_addr",  axi.ar_addr,         64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait read
        run_txn(1'b0, 64'h8000_0010, 64'd0, 8'h00, 3'd3, 1,
                64'h1122_3344_5566_7788, 2'b00, 0, 0, 0);
        chk("rd_ar_addr",  ar_addr_s,           64'h8000_0010);
        chk("rd_ar_len",   64'(ar_len_s),       64'd0);
        chk("rd_ar_size",  64'(ar_size_s),      64'd3);
        chk("rd_ar_burst", 64'(ar_burst_s),     64'd1);
        chk("rd_ar_id",    64'(ar_id_s),        64'd0);
        chk("rd_ar_cnt",   64'(ar_cyc),         64'd1);
        chk("rd_latency",  64'(lat),            64'd4);
        chk("rd_rdy_cnt",  64'(rdy_cnt),        64'd1);
        chk("rd_extra_v",  64'(extra_v),        64'd0);
        chk("rd_data",     ram_rw_data_o,       64'h1122_3344_5566_7788);

        // Write with aw_ready delayed 3 cycles, w_ready immediate
        run_txn(1'b1, 64'h8000_0008, 64'h0000_0000_DEAD_BEEF, 8'h0F, 3'd3, 3,
                64'd0, 2'b00, 0, 0, 0);
        chk("wr_w_cycles",  64'(w_cyc),       64'd1);
        chk("wr_aw_cycles", 64'(aw_cyc),      64'd3);
        chk("wr_aw_addr",   aw_addr_s,        64'h8000_0008);
        chk("wr_aw_len",    64'(aw_len_s),    64'd0);
        chk("wr_aw_burst",  64'(aw_burst_s),  64'd1);
        chk("wr_aw_id",     64'(aw_id_s),     64'd0);
        chk("wr_w_data",    w_data_s,         64'h0000_0000_DEAD_BEEF);
        chk("wr_w_strb",    64'(w_strb_s),    64'h0F);
        chk("wr_w_last",    64'(w_last_s),    64'd1);
        chk("wr_ar_cnt",    64'(ar_cyc),      64'd0);
        chk("wr_latency",   64'(lat),         64'd6);
        chk("wr_rdy_cnt",   64'(rdy_cnt),     64'd1);
        chk("wr_data_hold", ram_rw_data_o,    64'h1122_3344_5566_7788);
        chk("wr_bus_err",   64'(bus_err_o),   64'd0);

        // Back-to-back: read then write with cen held high
        run_txn(1'b0, 64'h8000_0020, 64'd0, 8'h00, 3'd3, 1,
                64'hA5A5_5A5A_0123_4567, 2'b00, 1, 0, 0);
        chk("b2b_rd_latency", 64'(lat),    64'd4);
        chk("b2b_rd_ar_cnt",  64'(ar_cyc), 64'd1);
        chk("b2b_rd_data",    ram_rw_data_o, 64'hA5A5_5A5A_0123_4567);
        run_txn(1'b1, 64'h8000_0018, 64'h0000_0000_CAFE_F00D, 8'hFF, 3'd3, 1,
                64'd0, 2'b00, 0, 0, 0);
        chk("b2b_wr_ar_cnt",  64'(ar_cyc),  64'd0);
        chk("b2b_wr_aw_cnt",  64'(aw_cyc),  64'd1);
        chk("b2b_wr_first_v", 64'(first_v), 64'd3);
        chk("b2b_wr_aw_addr", aw_addr_s,    64'h8000_0018);
        chk("b2b_wr_latency", 64'(lat),     64'd5);
        chk("b2b_wr_rdy_cnt", 64'(rdy_cnt), 64'd1);
        chk("b2b_wr_extra_v", 64'(extra_v), 64'd0);
        chk("b2b_data_hold",  ram_rw_data_o, 64'hA5A5_5A5A_0123_4567);

        // Inputs scrambled while in RD_DATA
        run_txn(1'b0, 64'h8000_0030, 64'd0, 8'h00, 3'd3, 1,
                64'h0F1E_2D3C_4B5A_6978, 2'b00, 0, 1, 0);
        chk("scr_ar_addr_latched", axi.ar_addr,     64'h8000_0030);
        chk("scr_ar_size_latched", 64'(axi.ar_size), 64'd3);
        chk("scr_aw_cnt",          64'(aw_cyc),      64'd0);
        chk("scr_latency",         64'(lat),         64'd4);
        chk("scr_data",            ram_rw_data_o,    64'h0F1E_2D3C_4B5A_6978);
        chk("scr_rdy_cnt",         64'(rdy_cnt),     64'd1);

        // Error response on write, then a clean read
        run_txn(1'b1, 64'h8000_0040, 64'h1111, 8'h03, 3'd3, 1,
                64'd0, 2'b10, 0, 0, 0);
        chk("err_rdy_cnt", 64'(rdy_cnt),   64'd1);
        chk("err_bus_err", 64'(bus_err_o), 64'(exp_err));
        run_txn(1'b0, 64'h8000_0048, 64'd0, 8'h00, 3'd3, 1,
                64'h7777_8888_9999_AAAA, 2'b00, 0, 0, 0);
        chk("err_sticky",  64'(bus_err_o), 64'(exp_err));
        chk("err_rd_data", ram_rw_data_o,  64'h7777_8888_9999_AAAA);

        // Reset while waiting in WR_RESP
        run_txn(1'b1, 64'h8000_0050, 64'h2222, 8'hFF, 3'd3, 1,
                64'd0, 2'b00, 0, 0, 1);
        chk("abort_b_ready_seen", 64'(axi.b_ready), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_state",    64'(dut.r_state),     64'(IDLE));
        chk("abort_ready",    64'(ram_rw_ready_o),  64'd0);
        chk("abort_b_ready",  64'(axi.b_ready),     64'd0);
        chk("abort_aw_valid", 64'(axi.aw_valid),    64'd0);
        chk("abort_w_valid",  64'(axi.w_valid),     64'd0);
        chk("abort_ar_valid", 64'(axi.ar_valid),    64'd0);
        chk("abort_bus_err",  64'(bus_err_o),       64'd0);
        rst_n = 1'b1;
        rdy_cnt = 0;
        extra_v = 0;
        repeat (3) begin
            @(negedge clk);
            if (ram_rw_ready_o) rdy_cnt++;
            if (axi.ar_valid || axi.aw_valid || axi.w_valid || axi.b_ready) extra_v++;
        end
        chk("abort_no_ready", 64'(rdy_cnt), 64'd0);
        chk("abort_quiet",    64'(extra_v), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
